// File: rtl/capture_seq_if.sv
// Bundle of control, buffer-write and readout signals for the capture sequencer.
// The master modport is the controlling side; the slave modport is the sequencer itself.
interface capture_seq_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              arm;
    logic              abort;
    logic              pause;
    logic              trig_hit;
    logic [ADDR_W-1:0] trig_len;
    logic [ADDR_W-1:0] pre_len;
    logic              rd_start;
    logic              rd_ready;

    logic              wt_en;
    logic [ADDR_W-1:0] wt_addr;
    logic [ADDR_W-1:0] trig_addr;
    logic              stop_flag;
    logic [ADDR_W-1:0] stop_addr;
    logic              rd_valid;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_last;
    logic [2:0]        state;

    modport master (
        output arm, abort, pause, trig_hit, trig_len, pre_len, rd_start, rd_ready,
        input  wt_en, wt_addr, trig_addr, stop_flag, stop_addr,
               rd_valid, rd_addr, rd_last, state
    );

    modport slave (
        input  arm, abort, pause, trig_hit, trig_len, pre_len, rd_start, rd_ready,
        output wt_en, wt_addr, trig_addr, stop_flag, stop_addr,
               rd_valid, rd_addr, rd_last, state
    );
endinterface

// File: rtl/capture_seq.sv
// Pre/post-trigger capture sequencer driving a circular buffer, followed by an
// oldest-first readout of the retained window.
module capture_seq #(
    parameter int unsigned ADDR_W = 16
) (
    input  logic         trig_clk,
    input  logic         trig_rstn,
    capture_seq_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4,
        S_READ = 3'd5
    } state_e;

    state_e            state_q,     state_d;
    logic [ADDR_W-1:0] len_q,       len_d;
    logic [ADDR_W-1:0] pre_q,       pre_d;
    logic [ADDR_W-1:0] pre_cnt_q,   pre_cnt_d;
    logic [ADDR_W-1:0] post_cnt_q,  post_cnt_d;
    logic [ADDR_W-1:0] beat_cnt_q,  beat_cnt_d;
    logic [ADDR_W-1:0] wt_addr_q,   wt_addr_d;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic [ADDR_W-1:0] stop_addr_q, stop_addr_d;
    logic [ADDR_W-1:0] rd_addr_q,   rd_addr_d;
    logic              stop_flag_q, stop_flag_d;
    logic              rd_valid_q,  rd_valid_d;
    logic              rd_last_q,   rd_last_d;
    logic              wr_c;

    // Circular increment over a buffer whose last address is 'last'.
    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a,
                                                   input logic [ADDR_W-1:0] last);
        return (a == last) ? '0 : ADDR_W'(a + 1'b1);
    endfunction

    always_ff @(posedge trig_clk or negedge trig_rstn) begin
        if (!trig_rstn) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            pre_q       <= '0;
            pre_cnt_q   <= '0;
            post_cnt_q  <= '0;
            beat_cnt_q  <= '0;
            wt_addr_q   <= '0;
            trig_addr_q <= '0;
            stop_addr_q <= '0;
            rd_addr_q   <= '0;
            stop_flag_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            pre_q       <= pre_d;
            pre_cnt_q   <= pre_cnt_d;
            post_cnt_q  <= post_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            wt_addr_q   <= wt_addr_d;
            trig_addr_q <= trig_addr_d;
            stop_addr_q <= stop_addr_d;
            rd_addr_q   <= rd_addr_d;
            stop_flag_q <= stop_flag_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        pre_d       = pre_q;
        pre_cnt_d   = pre_cnt_q;
        post_cnt_d  = post_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        wt_addr_d   = wt_addr_q;
        trig_addr_d = trig_addr_q;
        stop_addr_d = stop_addr_q;
        rd_addr_d   = rd_addr_q;
        stop_flag_d = stop_flag_q;
        rd_valid_d  = rd_valid_q;
        rd_last_d   = rd_last_q;
        wr_c        = ((state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST))
                      && !bus.pause;

        if (bus.abort) begin
            state_d     = S_IDLE;
            stop_flag_d = 1'b0;
            rd_valid_d  = 1'b0;
            rd_last_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Lengths are latched here so the capture ignores later input changes.
                    if (bus.arm) begin
                        len_d     = bus.trig_len;
                        pre_d     = (bus.pre_len > bus.trig_len) ? bus.trig_len : bus.pre_len;
                        wt_addr_d = '0;
                        pre_cnt_d = '0;
                        state_d   = (pre_d == '0) ? S_WAIT : S_PRE;
                    end
                end
                S_PRE: begin
                    if (wr_c) begin
                        wt_addr_d = wrap_inc(wt_addr_q, len_q);
                        pre_cnt_d = ADDR_W'(pre_cnt_q + 1'b1);
                        if (pre_cnt_d == pre_q) state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wr_c) begin
                        wt_addr_d = wrap_inc(wt_addr_q, len_q);
                        if (bus.trig_hit) begin
                            trig_addr_d = wt_addr_q;
                            post_cnt_d  = ADDR_W'(len_q - pre_q);
                            if (post_cnt_d == '0) begin
                                state_d     = S_DONE;
                                stop_addr_d = wt_addr_q;
                                stop_flag_d = 1'b1;
                            end else begin
                                state_d = S_POST;
                            end
                        end
                    end
                end
                S_POST: begin
                    if (wr_c) begin
                        wt_addr_d  = wrap_inc(wt_addr_q, len_q);
                        post_cnt_d = ADDR_W'(post_cnt_q - 1'b1);
                        if (post_cnt_d == '0) begin
                            state_d     = S_DONE;
                            stop_addr_d = wt_addr_q;
                            stop_flag_d = 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    // Oldest retained sample sits just after the final write.
                    if (bus.rd_start) begin
                        state_d    = S_READ;
                        rd_addr_d  = wrap_inc(stop_addr_q, len_q);
                        rd_valid_d = 1'b1;
                        rd_last_d  = (len_q == '0);
                        beat_cnt_d = '0;
                    end
                end
                S_READ: begin
                    if (rd_valid_q && bus.rd_ready) begin
                        if (rd_last_q) begin
                            state_d     = S_IDLE;
                            stop_flag_d = 1'b0;
                            rd_valid_d  = 1'b0;
                            rd_last_d   = 1'b0;
                        end else begin
                            rd_addr_d  = wrap_inc(rd_addr_q, len_q);
                            beat_cnt_d = ADDR_W'(beat_cnt_q + 1'b1);
                            rd_last_d  = (beat_cnt_d == len_q);
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign bus.wt_en     = wr_c;
    assign bus.wt_addr   = wt_addr_q;
    assign bus.trig_addr = trig_addr_q;
    assign bus.stop_flag = stop_flag_q;
    assign bus.stop_addr = stop_addr_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.rd_last   = rd_last_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_capture_seq.sv
// Randomized bench for capture_seq: a write-count model predicts addresses,
// trigger/stop positions and the oldest-first readout order.
module tb_capture_seq;
    localparam int unsigned AW = 16;

    logic clk;
    logic rstn;
    int   errors = 0;
    int   checks = 0;
    int   last_trig = 0;

    capture_seq_if #(.ADDR_W(AW)) bus ();
    capture_seq #(.ADDR_W(AW)) dut (.trig_clk(clk), .trig_rstn(rstn), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.arm = 0; bus.abort = 0; bus.pause = 0; bus.trig_hit = 0;
        bus.rd_start = 0; bus.rd_ready = 0;
    endtask

    // Model: write n lands at n mod depth; trigger is the first unpaused write
    // at index >= effective pre count with trig_hit; L-Pe more writes follow.
    task automatic do_capture(input int L, input int P, input int hit_pct, input int pause_pct,
                              input int force_hit_at, output int trig_o, output int stop_o);
        int D, Pe, n, t, total, cyc, exp_state;
        logic ps, h;
        D = L + 1; Pe = (P < L) ? P : L; n = 0; t = -1; total = -1; cyc = 0;
        checks++;
        if (bus.state !== 3'd0) begin
            errors++; $display("FAIL cap_idle_before_arm: got %0d expected 0", bus.state);
        end
        bus.arm = 1; bus.trig_len = AW'(L); bus.pre_len = AW'(P);
        tick();
        bus.arm = 0; bus.trig_len = AW'($urandom); bus.pre_len = AW'($urandom);
        while (!(total >= 0 && n == total)) begin
            if (cyc > 3000) begin
                checks++; errors++;
                $display("FAIL cap_timeout: got %0d writes expected %0d", n, total);
                bus.abort = 1; tick(); bus.abort = 0;
                break;
            end
            cyc++;
            ps = ($urandom_range(99) < pause_pct);
            if (force_hit_at >= 0) h = (n >= force_hit_at);
            else h = ($urandom_range(99) < hit_pct) || (cyc > 200);
            bus.pause = ps; bus.trig_hit = h;
            #1;
            exp_state = (n < Pe) ? 1 : ((t < 0) ? 2 : 3);
            checks++;
            if (bus.state !== 3'(exp_state)) begin
                errors++; $display("FAIL cap_state: got %0d expected %0d (write %0d)", bus.state, exp_state, n);
            end
            checks++;
            if (bus.wt_en !== !ps) begin
                errors++; $display("FAIL cap_wt_en: got %0b expected %0b", bus.wt_en, !ps);
            end
            checks++;
            if (bus.wt_addr !== AW'(n % D)) begin
                errors++; $display("FAIL cap_wt_addr: got %0d expected %0d", bus.wt_addr, n % D);
            end
            if (!ps) begin
                if (n >= Pe && t < 0 && h) begin
                    t = n; total = t + (L - Pe) + 1;
                end
                n++;
            end
            tick();
        end
        bus.pause = 0; bus.trig_hit = 0;
        #1;
        trig_o = (t < 0) ? -1 : t % D;
        stop_o = (total < 1) ? -1 : (total - 1) % D;
        checks++;
        if (bus.state !== 3'd4 || bus.stop_flag !== 1'b1 || bus.wt_en !== 1'b0) begin
            errors++;
            $display("FAIL cap_done: got state=%0d stop_flag=%0b wt_en=%0b expected 4/1/0",
                     bus.state, bus.stop_flag, bus.wt_en);
        end
        checks++;
        if (bus.trig_addr !== AW'(trig_o)) begin
            errors++; $display("FAIL cap_trig_addr: got %0d expected %0d", bus.trig_addr, trig_o);
        end
        checks++;
        if (bus.stop_addr !== AW'(stop_o)) begin
            errors++; $display("FAIL cap_stop_addr: got %0d expected %0d", bus.stop_addr, stop_o);
        end
        last_trig = trig_o;
    endtask

    // Readout must visit (stop+1+k) mod depth for k = 0..L, oldest first.
    task automatic do_readout(input int L, input int stop, input int ready_pct);
        int D, k, cyc, exp_addr;
        logic rdy;
        D = L + 1; k = 0; cyc = 0;
        bus.rd_start = 1;
        tick();
        bus.rd_start = 0;
        while (k <= L) begin
            if (cyc > 1000) begin
                checks++; errors++;
                $display("FAIL rd_timeout: got %0d beats expected %0d", k, L + 1);
                bus.abort = 1; tick(); bus.abort = 0;
                break;
            end
            cyc++;
            rdy = ($urandom_range(99) < ready_pct) || (cyc > 300);
            bus.rd_ready = rdy;
            bus.pause = ($urandom_range(99) < 30);
            #1;
            exp_addr = (stop + 1 + k) % D;
            checks++;
            if (bus.state !== 3'd5 || bus.rd_valid !== 1'b1 || bus.stop_flag !== 1'b1 || bus.wt_en !== 1'b0) begin
                errors++;
                $display("FAIL rd_status: got state=%0d valid=%0b stop_flag=%0b wt_en=%0b expected 5/1/1/0",
                         bus.state, bus.rd_valid, bus.stop_flag, bus.wt_en);
            end
            checks++;
            if (bus.rd_addr !== AW'(exp_addr)) begin
                errors++; $display("FAIL rd_addr: got %0d expected %0d (beat %0d)", bus.rd_addr, exp_addr, k + 1);
            end
            checks++;
            if (bus.rd_last !== (k == L)) begin
                errors++; $display("FAIL rd_last: got %0b expected %0b (beat %0d)", bus.rd_last, (k == L), k + 1);
            end
            if (rdy) k++;
            tick();
        end
        bus.rd_ready = 0; bus.pause = 0;
        #1;
        checks++;
        if (bus.state !== 3'd0 || bus.stop_flag !== 1'b0 || bus.rd_valid !== 1'b0 || bus.rd_last !== 1'b0) begin
            errors++;
            $display("FAIL rd_end: got state=%0d stop_flag=%0b valid=%0b last=%0b expected 0/0/0/0",
                     bus.state, bus.stop_flag, bus.rd_valid, bus.rd_last);
        end
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if (bus.state !== 3'd0 || bus.wt_addr !== '0 || bus.trig_addr !== '0 || bus.stop_addr !== '0 ||
            bus.rd_addr !== '0 || bus.wt_en !== 1'b0 || bus.stop_flag !== 1'b0 ||
            bus.rd_valid !== 1'b0 || bus.rd_last !== 1'b0) begin
            errors++;
            $display("FAIL %s: got state=%0d wa=%0d ta=%0d sa=%0d ra=%0d we=%0b sf=%0b rv=%0b rl=%0b expected all 0",
                     tag, bus.state, bus.wt_addr, bus.trig_addr, bus.stop_addr, bus.rd_addr,
                     bus.wt_en, bus.stop_flag, bus.rd_valid, bus.rd_last);
        end
    endtask

    task automatic test_reset();
        rstn = 0; idle_inputs(); bus.trig_len = '0; bus.pre_len = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_state");
        @(negedge clk); rstn = 1;
        tick();
    endtask

    task automatic test_basic();
        int t, s;
        do_capture(7, 3, 0, 0, 8, t, s);
        checks++;
        if (bus.trig_addr !== AW'(0) || bus.stop_addr !== AW'(4)) begin
            errors++; $display("FAIL basic_addrs: got trig=%0d stop=%0d expected 0/4", bus.trig_addr, bus.stop_addr);
        end
        do_readout(7, 4, 100);
    endtask

    task automatic test_clamp_and_arm_in_done();
        int t, s;
        do_capture(7, 9, 0, 0, 0, t, s);
        checks++;
        if (bus.trig_addr !== AW'(7) || bus.stop_addr !== AW'(7)) begin
            errors++; $display("FAIL clamp_addrs: got trig=%0d stop=%0d expected 7/7", bus.trig_addr, bus.stop_addr);
        end
        bus.arm = 1; bus.trig_len = AW'(3); bus.pre_len = AW'(1);
        tick();
        bus.arm = 0;
        #1;
        checks++;
        if (bus.state !== 3'd4 || bus.stop_addr !== AW'(7) || bus.stop_flag !== 1'b1) begin
            errors++; $display("FAIL arm_in_done: got state=%0d stop=%0d flag=%0b expected 4/7/1",
                               bus.state, bus.stop_addr, bus.stop_flag);
        end
        do_readout(7, 7, 50);
    endtask

    task automatic test_abort();
        int t, s;
        bus.abort = 1; bus.arm = 1; bus.trig_len = AW'(5); bus.pre_len = AW'(1);
        tick();
        bus.abort = 0; bus.arm = 0;
        #1;
        checks++;
        if (bus.state !== 3'd0) begin
            errors++; $display("FAIL abort_over_arm: got %0d expected 0", bus.state);
        end
        bus.arm = 1;
        tick();
        bus.arm = 0;
        tick(); tick();
        bus.abort = 1; bus.trig_hit = 1;
        tick();
        bus.abort = 0; bus.trig_hit = 0;
        #1;
        checks++;
        if (bus.state !== 3'd0 || bus.trig_addr !== AW'(last_trig) || bus.stop_flag !== 1'b0 || bus.wt_en !== 1'b0) begin
            errors++; $display("FAIL abort_wait: got state=%0d trig=%0d flag=%0b we=%0b expected 0/%0d/0/0",
                               bus.state, bus.trig_addr, bus.stop_flag, bus.wt_en, last_trig);
        end
        do_capture(4, 2, 40, 20, -1, t, s);
        bus.rd_start = 1; tick(); bus.rd_start = 0;
        bus.rd_ready = 0; tick();
        bus.abort = 1; bus.rd_ready = 1; tick(); bus.abort = 0; bus.rd_ready = 0;
        #1;
        checks++;
        if (bus.state !== 3'd0 || bus.rd_valid !== 1'b0 || bus.rd_last !== 1'b0 || bus.stop_flag !== 1'b0) begin
            errors++; $display("FAIL abort_read: got state=%0d valid=%0b last=%0b flag=%0b expected 0/0/0/0",
                               bus.state, bus.rd_valid, bus.rd_last, bus.stop_flag);
        end
    endtask

    task automatic test_len0();
        int t, s;
        do_capture(0, $urandom_range(0, 3), 50, 30, -1, t, s);
        checks++;
        if (bus.trig_addr !== AW'(0) || bus.stop_addr !== AW'(0)) begin
            errors++; $display("FAIL len0_addrs: got trig=%0d stop=%0d expected 0/0", bus.trig_addr, bus.stop_addr);
        end
        do_readout(0, 0, 100);
    endtask

    task automatic test_random();
        int t, s, L;
        for (int i = 0; i < 8; i++) begin
            L = $urandom_range(0, 12);
            do_capture(L, $urandom_range(0, 15), 30, 25, -1, t, s);
            do_readout(L, s, 60);
        end
    endtask

    task automatic test_reset_mid_read();
        int t, s;
        do_capture(6, 2, 40, 0, -1, t, s);
        bus.rd_start = 1; tick(); bus.rd_start = 0;
        bus.rd_ready = 1; tick(); tick();
        #2;
        rstn = 0;
        #1;
        check_all_zero("reset_mid_read");
        @(negedge clk); bus.rd_ready = 0; rstn = 1;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp_and_arm_in_done();
        test_abort();
        test_len0();
        test_random();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
